// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: zero-cycle lookup from if_pc, zero-cycle mispredict check on ID resolution.
// Training and performance counters update on the rising clk edge; no backpressure, at most one update per cycle.
module branch_predictor #(
    parameter int IDX_BITS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] if_pc,
    output logic        pred_taken,
    output logic [63:0] pred_next_pc,
    input  logic        upd_valid,
    input  logic [63:0] upd_pc,
    input  logic        upd_taken,
    input  logic [63:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [63:0] upd_pred_target,
    output logic        mispredict,
    output logic [63:0] redirect_pc,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);
    localparam int N     = 1 << IDX_BITS;
    localparam int TAG_W = 64 - IDX_BITS - 2;

    logic             valid_q [N];
    logic [TAG_W-1:0] tag_q   [N];
    logic [63:0]      tgt_q   [N];
    logic [1:0]       ctr_q   [N];
    logic [31:0]      branch_cnt_q, branch_cnt_d;
    logic [31:0]      mispred_cnt_q, mispred_cnt_d;

    logic [IDX_BITS-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0]    lk_tag, up_tag;
    logic                lk_hit, up_hit;
    logic                upd_act;
    logic [63:0]         correct_pc;

    // Instruction alignment bits never participate in indexing or tagging.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{if_pc[1:0], upd_pc[1:0]};

    assign lk_idx  = if_pc[IDX_BITS+1:2];
    assign lk_tag  = if_pc[63:IDX_BITS+2];
    assign up_idx  = upd_pc[IDX_BITS+1:2];
    assign up_tag  = upd_pc[63:IDX_BITS+2];
    assign lk_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign up_hit  = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign upd_act = upd_valid && !reset;

    always_comb begin
        pred_taken   = !reset && lk_hit && ctr_q[lk_idx][1];
        pred_next_pc = pred_taken ? tgt_q[lk_idx] : if_pc + 64'd4;
    end

    always_comb begin
        correct_pc  = upd_taken ? upd_target : upd_pc + 64'd4;
        mispredict  = upd_act && ((upd_taken != upd_pred_taken) || (correct_pc != upd_pred_target));
        redirect_pc = upd_act ? correct_pc : 64'd0;
    end

    logic        wr_en;
    logic [1:0]  ctr_d;
    logic [63:0] tgt_d;

    always_comb begin
        wr_en = 1'b0;
        ctr_d = ctr_q[up_idx];
        tgt_d = tgt_q[up_idx];
        if (upd_act) begin
            if (up_hit) begin
                wr_en = 1'b1;
                if (upd_taken) begin
                    ctr_d = (ctr_q[up_idx] == 2'd3) ? 2'd3 : ctr_q[up_idx] + 2'd1;
                    tgt_d = upd_target;
                end else begin
                    ctr_d = (ctr_q[up_idx] == 2'd0) ? 2'd0 : ctr_q[up_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                // Fresh allocation starts weakly taken so one taken outcome predicts taken.
                wr_en = 1'b1;
                ctr_d = 2'd2;
                tgt_d = upd_target;
            end
        end
    end

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (upd_act && branch_cnt_q != 32'hFFFF_FFFF)
            branch_cnt_d = branch_cnt_q + 32'd1;
        if (mispredict && mispred_cnt_q != 32'hFFFF_FFFF)
            mispred_cnt_d = mispred_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                ctr_q[i]   <= 2'b01;
            end
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (wr_en) begin
                valid_q[up_idx] <= 1'b1;
                tag_q[up_idx]   <= up_tag;
                tgt_q[up_idx]   <= tgt_d;
                ctr_q[up_idx]   <= ctr_d;
            end
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branch_count     = branch_cnt_q;
    assign mispredict_count = mispred_cnt_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: each driven cycle pushes its expected outputs, the negedge monitor pops and compares.
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] if_pc;
    logic        pred_taken;
    logic [63:0] pred_next_pc;
    logic        upd_valid;
    logic [63:0] upd_pc;
    logic        upd_taken;
    logic [63:0] upd_target;
    logic        upd_pred_taken;
    logic [63:0] upd_pred_target;
    logic        mispredict;
    logic [63:0] redirect_pc;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    branch_predictor #(.IDX_BITS(4)) dut (
        .clk(clk), .reset(reset), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_next_pc(pred_next_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .mispredict(mispredict),
        .redirect_pc(redirect_pc), .branch_count(branch_count),
        .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] step;
        logic        pt;
        logic [63:0] npc;
        logic        mis;
        logic [63:0] red;
        logic [31:0] bcnt;
        logic [31:0] mcnt;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          step_no  = 0;
    logic [31:0] exp_b    = 0;
    logic [31:0] exp_m    = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check_eq($sformatf("s%0d_pred_taken", e.step), {63'd0, pred_taken}, {63'd0, e.pt});
            check_eq($sformatf("s%0d_pred_next_pc", e.step), pred_next_pc, e.npc);
            check_eq($sformatf("s%0d_mispredict", e.step), {63'd0, mispredict}, {63'd0, e.mis});
            check_eq($sformatf("s%0d_redirect_pc", e.step), redirect_pc, e.red);
            check_eq($sformatf("s%0d_branch_count", e.step), {32'd0, branch_count}, {32'd0, e.bcnt});
            check_eq($sformatf("s%0d_mispredict_count", e.step), {32'd0, mispredict_count}, {32'd0, e.mcnt});
        end
    end

    // One cycle: drive inputs, queue the expected outputs, advance past the edge.
    task automatic cyc(input logic rst, input logic [63:0] ipc,
                       input logic uv, input logic [63:0] upc, input logic ut,
                       input logic [63:0] utgt, input logic upt, input logic [63:0] uptgt,
                       input logic ept, input logic [63:0] enpc,
                       input logic emis, input logic [63:0] ered);
        exp_t e;
        reset = rst; if_pc = ipc; upd_valid = uv; upd_pc = upc; upd_taken = ut;
        upd_target = utgt; upd_pred_taken = upt; upd_pred_target = uptgt;
        step_no++;
        e.step = step_no; e.pt = ept; e.npc = enpc; e.mis = emis; e.red = ered;
        e.bcnt = exp_b; e.mcnt = exp_m;
        exp_q.push_back(e);
        if (rst) begin
            exp_b = 0;
            exp_m = 0;
        end else if (uv) begin
            exp_b = exp_b + 1;
            if (emis) exp_m = exp_m + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic look(input logic [63:0] ipc, input logic ept, input logic [63:0] enpc);
        cyc(1'b0, ipc, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 64'd0, ept, enpc, 1'b0, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; if_pc = 0; upd_valid = 0; upd_pc = 0; upd_taken = 0;
        upd_target = 0; upd_pred_taken = 0; upd_pred_target = 0;
        @(posedge clk);
        #1;
        // Held in reset with an update present: outputs forced idle, nothing counted
        cyc(1, 64'h100, 1, 64'h100, 1, 64'h80, 0, 64'h104, 0, 64'h104, 0, 64'h0);
        // Cold lookup
        look(64'h100, 0, 64'h104);
        // Cold taken branch; same-cycle lookup sees pre-update contents
        cyc(0, 64'h100, 1, 64'h100, 1, 64'h80, 0, 64'h104, 0, 64'h104, 1, 64'h80);
        look(64'h100, 1, 64'h80);
        // Hysteresis: ctr 2 -> 1 -> 0 -> 1 -> 2
        cyc(0, 64'h100, 1, 64'h100, 0, 64'h80, 1, 64'h80, 1, 64'h80, 1, 64'h104);
        cyc(0, 64'h100, 1, 64'h100, 0, 64'h80, 0, 64'h104, 0, 64'h104, 0, 64'h104);
        cyc(0, 64'h100, 1, 64'h100, 1, 64'h80, 0, 64'h104, 0, 64'h104, 1, 64'h80);
        look(64'h100, 0, 64'h104);
        cyc(0, 64'h100, 1, 64'h100, 1, 64'h80, 0, 64'h104, 0, 64'h104, 1, 64'h80);
        look(64'h100, 1, 64'h80);
        // Saturation at 3 with correct predictions, then one not-taken keeps taken
        for (int i = 0; i < 4; i++)
            cyc(0, 64'h100, 1, 64'h100, 1, 64'h80, 1, 64'h80, 1, 64'h80, 0, 64'h80);
        cyc(0, 64'h100, 1, 64'h100, 0, 64'h80, 1, 64'h80, 1, 64'h80, 1, 64'h104);
        look(64'h100, 1, 64'h80);
        // Aliasing: 0x140 shares index 0 with 0x100
        look(64'h140, 0, 64'h144);
        cyc(0, 64'h140, 1, 64'h140, 1, 64'h200, 0, 64'h144, 0, 64'h144, 1, 64'h200);
        look(64'h100, 0, 64'h104);
        look(64'h140, 1, 64'h200);
        // Right direction, wrong target still mispredicts and retargets
        cyc(0, 64'h140, 1, 64'h140, 1, 64'h300, 1, 64'h200, 1, 64'h200, 1, 64'h300);
        look(64'h140, 1, 64'h300);
        // Miss + not-taken at an aliasing PC must not write
        cyc(0, 64'h104, 1, 64'h180, 0, 64'h999, 0, 64'h184, 0, 64'h108, 0, 64'h184);
        look(64'h140, 1, 64'h300);
        // 64-bit wrap of pc+4
        cyc(0, 64'hFFFF_FFFF_FFFF_FFFC, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h40, 0, 64'h0,
            0, 64'h0, 0, 64'h0);
        // Reset concurrent with an update: discarded, table and counts cleared
        cyc(1, 64'h140, 1, 64'h140, 1, 64'h500, 0, 64'h144, 0, 64'h144, 0, 64'h0);
        look(64'h140, 0, 64'h144);
        look(64'h100, 0, 64'h104);
        // Back-to-back updates after reset count one per cycle
        cyc(0, 64'h8, 1, 64'h8, 1, 64'h40, 0, 64'hC, 0, 64'hC, 1, 64'h40);
        cyc(0, 64'h8, 1, 64'h8, 1, 64'h40, 1, 64'h40, 1, 64'h40, 0, 64'h40);
        look(64'h8, 1, 64'h40);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
